// File: rtl/ttl_arb_pkg.sv
// Shared types and helpers for the TTL bus arbiter.
// Holds the arbiter state encoding, the decoder enable triples and the
// rotating-priority winner search used by ttl_rr_pick.
package ttl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        DEAD  = 2'd3
    } arb_state_t;

    // Enable pins of the 74138-style decoder, in pin order {E1_n, E2_n, E3}
    typedef struct packed {
        logic e1_n;
        logic e2_n;
        logic e3;
    } dec_en_t;

    localparam dec_en_t DEC_ON  = 3'b001;
    localparam dec_en_t DEC_OFF = 3'b110;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First set request scanning upward from ptr+1, wrapping modulo n_req.
    // The agent at ptr itself is examined last, so the previous winner has
    // the lowest priority.
    function automatic rr_pick_t rr_winner(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n_req);
        rr_pick_t   res;
        int         cand;
        logic [2:0] idx;
        res  = '0;
        cand = 0;
        idx  = '0;
        for (int k = 1; k <= 8; k++) begin
            if (!res.valid && (k <= n_req)) begin
                cand = (int'(ptr) + k) % n_req;
                idx  = 3'(cand);
                if (req[idx]) begin
                    res.valid = 1'b1;
                    res.idx   = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ttl_bus_arbiter_pick.sv
// ttl_rr_pick: combinational rotating-priority picker.
// Request lines at or above N_REQ are masked off before the search.
module ttl_rr_pick
    import ttl_arb_pkg::*;
#(
    parameter int N_REQ = 8
) (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] winner,
    output logic       valid
);

    logic [7:0] req_masked;
    rr_pick_t   pick;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            if (gi < N_REQ) begin : g_live
                assign req_masked[gi] = req[gi];
            end else begin : g_absent
                assign req_masked[gi] = 1'b0;
            end
        end
    endgenerate

    // Search the masked requests starting just after the pointer
    always_comb begin
        pick = rr_winner(req_masked, ptr, N_REQ);
    end

    assign winner = pick.idx;
    assign valid  = pick.valid;

endmodule

// File: rtl/ttl_bus_arbiter.sv
// ttl_bus_arbiter: round-robin owner of one 8-bit TTL bus segment.
// Sequences a 74138-style decoder and 74244-style buffer enables through
// IDLE -> SETUP -> DRIVE -> DEAD so two drivers never overlap.
// Optional feature macro: TTL_ARB_LOCK_EN (lock extends a grant past
// MAX_HOLD until lock drops). Without it lock is ignored.
module ttl_bus_arbiter
    import ttl_arb_pkg::*;
#(
    parameter int N_REQ     = 8,
    parameter int SETUP_CYC = 1,
    parameter int MAX_HOLD  = 16,
    parameter int DEAD_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       lock,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       dec_e1_n,
    output logic       dec_e2_n,
    output logic       dec_e3,
    output logic       buf_g_n,
    output logic       busy
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t        state_reg, state_next;
    logic [7:0]        grant_reg, grant_next;
    logic [2:0]        sel_reg, sel_next;
    dec_en_t           dec_reg, dec_next;
    logic              buf_g_n_reg, buf_g_n_next;
    logic              busy_reg, busy_next;
    logic [2:0]        ptr_reg, ptr_next;
    logic [3:0]        setup_cnt_reg, setup_cnt_next;
    logic [3:0]        dead_cnt_reg, dead_cnt_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic [2:0] pick_idx;
    logic       pick_valid;
    logic       holder_req;
    logic       hold_at_max;
    logic       drive_end;
    logic       arbitrate;

    ttl_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign holder_req  = req[sel_reg];
    // The hold counter saturates at MAX_HOLD so a locked grant keeps a
    // stable "limit reached" indication; MAX_HOLD of 0 disables the limit.
    assign hold_at_max = (MAX_HOLD > 0) && (hold_cnt_reg >= HOLD_W'(MAX_HOLD));

`ifdef TTL_ARB_LOCK_EN
    assign drive_end = !holder_req || (hold_at_max && !lock);
`else
    logic lock_unused;
    assign lock_unused = lock;
    assign drive_end   = !holder_req || hold_at_max;
`endif

    // State, output and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            sel_reg       <= '0;
            dec_reg       <= DEC_OFF;
            buf_g_n_reg   <= 1'b1;
            busy_reg      <= 1'b0;
            ptr_reg       <= 3'(N_REQ - 1);
            setup_cnt_reg <= '0;
            dead_cnt_reg  <= '0;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            sel_reg       <= sel_next;
            dec_reg       <= dec_next;
            buf_g_n_reg   <= buf_g_n_next;
            busy_reg      <= busy_next;
            ptr_reg       <= ptr_next;
            setup_cnt_reg <= setup_cnt_next;
            dead_cnt_reg  <= dead_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
        end
    end

    // Next-state and next-output logic; every exit from SETUP/DRIVE passes
    // through DEAD with buffer and decoder both off
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        sel_next       = sel_reg;
        dec_next       = dec_reg;
        buf_g_n_next   = buf_g_n_reg;
        ptr_next       = ptr_reg;
        setup_cnt_next = setup_cnt_reg;
        dead_cnt_next  = dead_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        arbitrate      = 1'b0;

        case (state_reg)
            IDLE: begin
                arbitrate = 1'b1;
            end
            SETUP: begin
                if (!holder_req) begin
                    state_next    = DEAD;
                    grant_next    = '0;
                    dec_next      = DEC_OFF;
                    buf_g_n_next  = 1'b1;
                    dead_cnt_next = 4'd1;
                end else if (setup_cnt_reg == 4'(SETUP_CYC)) begin
                    state_next    = DRIVE;
                    buf_g_n_next  = 1'b0;
                    hold_cnt_next = HOLD_W'(1);
                end else begin
                    setup_cnt_next = setup_cnt_reg + 4'd1;
                end
            end
            DRIVE: begin
                if (drive_end) begin
                    state_next    = DEAD;
                    grant_next    = '0;
                    dec_next      = DEC_OFF;
                    buf_g_n_next  = 1'b1;
                    dead_cnt_next = 4'd1;
                end else if (!hold_at_max) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            DEAD: begin
                if (dead_cnt_reg == 4'(DEAD_CYC)) begin
                    arbitrate = 1'b1;
                end else begin
                    dead_cnt_next = dead_cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // IDLE and the last DEAD cycle share the same grant decision
        if (arbitrate) begin
            if (pick_valid) begin
                state_next     = SETUP;
                grant_next     = 8'd1 << pick_idx;
                sel_next       = pick_idx;
                dec_next       = DEC_ON;
                buf_g_n_next   = 1'b1;
                ptr_next       = pick_idx;
                setup_cnt_next = 4'd1;
            end else begin
                state_next = IDLE;
            end
        end

        busy_next = (state_next != IDLE);
    end

    assign grant    = grant_reg;
    assign sel      = sel_reg;
    assign dec_e1_n = dec_reg.e1_n;
    assign dec_e2_n = dec_reg.e2_n;
    assign dec_e3   = dec_reg.e3;
    assign buf_g_n  = buf_g_n_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_ttl_bus_arbiter.sv
// Testbench for ttl_bus_arbiter (N_REQ=8, SETUP_CYC=1, MAX_HOLD=4, DEAD_CYC=1).
// Stimulus pushes expected grant transactions and output snapshots into
// queues; a negedge monitor reconstructs transactions and compares.
// Honours TTL_ARB_LOCK_EN for the lock scenario.
module tb_ttl_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic       lock;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       dec_e1_n, dec_e2_n, dec_e3;
    logic       buf_g_n;
    logic       busy;

    always #5 clk = ~clk;

    ttl_bus_arbiter #(
        .N_REQ     (8),
        .SETUP_CYC (1),
        .MAX_HOLD  (4),
        .DEAD_CYC  (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .lock     (lock),
        .grant    (grant),
        .sel      (sel),
        .dec_e1_n (dec_e1_n),
        .dec_e2_n (dec_e2_n),
        .dec_e3   (dec_e3),
        .buf_g_n  (buf_g_n),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        int         setup_cyc;
        int         drive_cyc;
        int         dead_before;
    } txn_t;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       buf_g_n;
        logic [2:0] dec;
        logic       busy;
    } snap_t;

    txn_t  exp_q[$];
    snap_t probe_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  done   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic [7:0] g, input logic [2:0] s, input int su,
                            input int dr, input int db);
        txn_t t;
        t.grant = g; t.sel = s; t.setup_cyc = su; t.drive_cyc = dr; t.dead_before = db;
        exp_q.push_back(t);
    endtask

    task automatic probe(input logic [7:0] g, input logic [2:0] s, input logic b,
                         input logic [2:0] d, input logic bz);
        snap_t p;
        p.grant = g; p.sel = s; p.buf_g_n = b; p.dec = d; p.busy = bz;
        probe_q.push_back(p);
    endtask

    // Monitor: snapshot probes, per-cycle invariants, transaction scoreboard
    initial begin
        txn_t  cur;
        txn_t  e;
        snap_t p;
        logic  in_txn;
        int    dead_run;
        in_txn   = 1'b0;
        dead_run = 0;
        cur      = '{8'h00, 3'd0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (done) break;

            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                chk("probe_grant", 32'(grant), 32'(p.grant));
                chk("probe_sel", 32'(sel), 32'(p.sel));
                chk("probe_buf_g_n", 32'(buf_g_n), 32'(p.buf_g_n));
                chk("probe_dec", 32'({dec_e1_n, dec_e2_n, dec_e3}), 32'(p.dec));
                chk("probe_busy", 32'(busy), 32'(p.busy));
            end

            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (!buf_g_n)
                chk("buf_needs_dec_and_grant", 32'({dec_e1_n, dec_e2_n, dec_e3, grant != 8'h00}), 32'b0011);
            if (grant != 8'h00)
                chk("sel_matches_grant", 32'(grant), 32'(8'd1 << sel));
            if (!busy)
                chk("idle_outputs", 32'({grant, buf_g_n, dec_e1_n, dec_e2_n, dec_e3}), 32'({8'h00, 4'b1110}));

            if (!reset_n) begin
                in_txn   = 1'b0;
                dead_run = 0;
            end else if (grant != 8'h00) begin
                if (!in_txn) begin
                    in_txn          = 1'b1;
                    cur.grant       = grant;
                    cur.sel         = sel;
                    cur.setup_cyc   = 0;
                    cur.drive_cyc   = 0;
                    cur.dead_before = dead_run;
                end else begin
                    chk("grant_stable", 32'(grant), 32'(cur.grant));
                end
                if (buf_g_n) cur.setup_cyc++;
                else         cur.drive_cyc++;
                dead_run = 0;
            end else begin
                if (in_txn) begin
                    in_txn = 1'b0;
                    $display("txn grant=%02h sel=%0d setup=%0d drive=%0d dead_before=%0d",
                             cur.grant, cur.sel, cur.setup_cyc, cur.drive_cyc, cur.dead_before);
                    chk("dead_entry_outputs", 32'({busy, buf_g_n, dec_e1_n, dec_e2_n, dec_e3}), 32'b11110);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_txn actual grant=%02h expected none", cur.grant);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_grant", 32'(cur.grant), 32'(e.grant));
                        chk("txn_sel", 32'(cur.sel), 32'(e.sel));
                        chk("txn_setup_cycles", cur.setup_cyc, e.setup_cyc);
                        chk("txn_drive_cycles", cur.drive_cyc, e.drive_cyc);
                        chk("txn_dead_before", cur.dead_before, e.dead_before);
                    end
                end
                if (busy) dead_run++;
                else      dead_run = 0;
            end
        end
        chk("expected_txns_consumed", exp_q.size(), 0);
        chk("no_open_txn", 32'(in_txn), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed stimulus
    initial begin
        reset_n = 1'b0;
        req     = 8'h00;
        lock    = 1'b0;

        // Reset values, then ten quiet cycles
        cyc(3);
        probe(8'h00, 3'd0, 1'b1, 3'b110, 1'b0);
        reset_n = 1'b1;
        cyc(10);
        probe(8'h00, 3'd0, 1'b1, 3'b110, 1'b0);

        // All agents requesting: 0..7 then 0, four drive cycles each
        for (int a = 0; a < 9; a++)
            push_txn(8'd1 << (a % 8), 3'(a % 8), 1, 4, (a == 0) ? 0 : 1);
        req = 8'hFF;
        cyc(1);
        probe(8'h01, 3'd0, 1'b1, 3'b001, 1'b1);
        cyc(53);
        probe(8'h00, 3'd0, 1'b1, 3'b110, 1'b1);
        req = 8'h00;
        cyc(3);

        // Single requester, released after two drive cycles
        push_txn(8'h04, 3'd2, 1, 2, 0);
        req = 8'h04;
        cyc(1);
        probe(8'h04, 3'd2, 1'b1, 3'b001, 1'b1);
        cyc(1);
        probe(8'h04, 3'd2, 1'b0, 3'b001, 1'b1);
        cyc(1);
        req = 8'h00;
        cyc(1);
        probe(8'h00, 3'd2, 1'b1, 3'b110, 1'b1);
        cyc(1);
        probe(8'h00, 3'd2, 1'b1, 3'b110, 1'b0);
        cyc(2);

        // Agent 3 withdraws during SETUP; agent 4 follows after one dead cycle
        push_txn(8'h08, 3'd3, 1, 0, 0);
        push_txn(8'h10, 3'd4, 1, 4, 1);
        req = 8'h18;
        cyc(1);
        probe(8'h08, 3'd3, 1'b1, 3'b001, 1'b1);
        req = 8'h10;
        cyc(1);
        probe(8'h00, 3'd3, 1'b1, 3'b110, 1'b1);
        cyc(1);
        probe(8'h10, 3'd4, 1'b1, 3'b001, 1'b1);
        cyc(5);
        req = 8'h00;
        cyc(3);

        // Lock scenario, agents 0 and 1
        req  = 8'h03;
        lock = 1'b1;
`ifdef TTL_ARB_LOCK_EN
        push_txn(8'h01, 3'd0, 1, 12, 0);
        push_txn(8'h02, 3'd1, 1, 4, 1);
        cyc(13);
        probe(8'h01, 3'd0, 1'b0, 3'b001, 1'b1);
        lock = 1'b0;
        cyc(1);
        probe(8'h00, 3'd0, 1'b1, 3'b110, 1'b1);
        cyc(6);
        req = 8'h00;
        cyc(3);
`else
        push_txn(8'h01, 3'd0, 1, 4, 0);
        push_txn(8'h02, 3'd1, 1, 4, 1);
        cyc(11);
        req  = 8'h00;
        lock = 1'b0;
        cyc(3);
`endif

        // Reset while agent 0 drives; pointer must restart so agent 0 wins again
        req = 8'h01;
        cyc(1);
        probe(8'h01, 3'd0, 1'b1, 3'b001, 1'b1);
        cyc(2);
        probe(8'h01, 3'd0, 1'b0, 3'b001, 1'b1);
        reset_n = 1'b0;
        req     = 8'h81;
        cyc(1);
        probe(8'h00, 3'd0, 1'b1, 3'b110, 1'b0);
        push_txn(8'h01, 3'd0, 1, 4, 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        probe(8'h01, 3'd0, 1'b1, 3'b001, 1'b1);
        cyc(5);
        req = 8'h00;
        cyc(3);

        done = 1'b1;
    end

endmodule
